// File: rtl/gpio_pkg.sv
// gpio_pkg: shared GPIO types (debouncer FSM states, interrupt source select)
package gpio_pkg;
  typedef enum logic {STABLE, CHANGING} deb_state_e;
  typedef enum logic [1:0] {IRQ_NONE, IRQ_RISE, IRQ_FALL, IRQ_BOTH} irq_mode_e;
endpackage

// File: rtl/gpio_debouncer.sv
// gpio_debouncer: glitch filter with rise/fall pulses and sticky interrupt
//   clk_i, rst_i (async, active-high), signal_i synchronized level, enable_i,
//   irq_mode_i (none/rise/fall/both), irq_ack_i; outputs stable_o, rise_o,
//   fall_o, irq_o, all registered.
module gpio_debouncer
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       signal_i,
  input  logic       enable_i,
  input  logic [1:0] irq_mode_i,
  input  logic       irq_ack_i,
  output logic       stable_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       irq_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  deb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic stable_q, rise_q, fall_q, pend_q;
  logic stable_d, rise_d, fall_d, pend_d;
  logic diff, accept, set_irq;
  irq_mode_e mode;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
    end
  // cnt_q is 0 in STABLE, so cnt_q+1 yields the first count as well
  always_comb begin
    diff    = signal_i != stable_q;
    cnt_inc = cnt_q + 1'b1;
    accept  = enable_i && diff && cnt_inc == CW'(DEBOUNCE_CYCLES);
    state_d = (!enable_i || !diff || accept) ? STABLE : CHANGING;
    cnt_d   = (state_d == CHANGING) ? cnt_inc : '0;
  end
  always_comb begin
    mode     = irq_mode_e'(irq_mode_i);
    stable_d = accept ? ~stable_q : stable_q;
    rise_d   = accept && !stable_q;
    fall_d   = accept && stable_q;
    set_irq  = (rise_d && (mode == IRQ_RISE || mode == IRQ_BOTH)) ||
               (fall_d && (mode == IRQ_FALL || mode == IRQ_BOTH));
    pend_d   = set_irq ? 1'b1 : irq_ack_i ? 1'b0 : pend_q;
  end
  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign irq_o    = pend_q;
endmodule

// File: tb/tb_gpio_debouncer.sv
// tb_gpio_debouncer: directed checks of debounce latency, glitch rejection, irq and reset
module tb_gpio_debouncer;
  logic clk = 0, rst = 1, rst_c = 1;
  logic sig_a = 0, sig_b = 0, sig_c = 1, en = 1, ack = 0;
  logic [1:0] mode = 2'b01;
  logic st_a, ri_a, fa_a, irq_a, st_b, ri_b, fa_b, irq_b, st_c, ri_c, fa_c, irq_c;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  gpio_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .signal_i(sig_a), .enable_i(en), .irq_mode_i(mode),
    .irq_ack_i(ack), .stable_o(st_a), .rise_o(ri_a), .fall_o(fa_a), .irq_o(irq_a));
  gpio_debouncer #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .signal_i(sig_b), .enable_i(en), .irq_mode_i(mode),
    .irq_ack_i(ack), .stable_o(st_b), .rise_o(ri_b), .fall_o(fa_b), .irq_o(irq_b));
  gpio_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b1)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .signal_i(sig_c), .enable_i(en), .irq_mode_i(2'b11),
    .irq_ack_i(1'b0), .stable_o(st_c), .rise_o(ri_c), .fall_o(fa_c), .irq_o(irq_c));
  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    chk("rst_stable_a", st_a, 0); chk("rst_rise_a", ri_a, 0);
    chk("rst_fall_a", fa_a, 0); chk("rst_irq_a", irq_a, 0);
    chk("rst_stable_c", st_c, 1);
    rst = 0; rst_c = 0;
    step(1);
    sig_a = 1;
    step(3);
    chk("lat_stable_early", st_a, 0); chk("lat_rise_early", ri_a, 0);
    step(1);
    chk("lat_stable", st_a, 1); chk("lat_rise", ri_a, 1);
    chk("lat_fall", fa_a, 0); chk("lat_irq", irq_a, 1);
    step(1);
    chk("rise_one_cycle", ri_a, 0); chk("irq_sticky", irq_a, 1);
    ack = 1; step(1); ack = 0;
    chk("ack_clears", irq_a, 0);
    sig_a = 0; step(4);
    chk("fall_stable", st_a, 0); chk("fall_pulse", fa_a, 1); chk("fall_no_irq_rise_mode", irq_a, 0);
    sig_a = 1; step(3); sig_a = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("glitch_stable", st_a, 0); chk("glitch_rise", ri_a, 0); chk("glitch_irq", irq_a, 0);
    end
    sig_a = 1; step(4);
    chk("post_glitch_stable", st_a, 1); chk("post_glitch_rise", ri_a, 1);
    mode = 2'b10; ack = 1; step(1); ack = 0;
    chk("mode_fall_cleared", irq_a, 0);
    sig_a = 0; step(4);
    chk("mf_fall_stable", st_a, 0); chk("mf_fall_irq", irq_a, 1);
    ack = 1; step(1); ack = 0;
    sig_a = 1; step(4);
    chk("mf_rise_stable", st_a, 1); chk("mf_rise_no_irq", irq_a, 0);
    sig_a = 0; step(4);
    chk("mf_fall2_irq", irq_a, 1);
    sig_a = 1; step(4);
    chk("mf_rise2_stable", st_a, 1); chk("mf_rise2_irq_held", irq_a, 1);
    sig_a = 0; step(3); ack = 1; step(1); ack = 0;
    chk("set_ack_fall", fa_a, 1); chk("set_wins", irq_a, 1);
    step(1);
    chk("set_wins_held", irq_a, 1);
    ack = 1; step(1); ack = 0;
    chk("ack_after", irq_a, 0);
    mode = 2'b01;
    sig_a = 1; step(2); en = 0; step(3);
    chk("dis_stable", st_a, 0); chk("dis_rise", ri_a, 0);
    en = 1; step(3);
    chk("reen_early", st_a, 0);
    step(1);
    chk("reen_stable", st_a, 1); chk("reen_rise", ri_a, 1); chk("reen_irq", irq_a, 1);
    chk("d1_idle", st_b, 0);
    sig_b = 1; step(1);
    chk("d1_stable_hi", st_b, 1); chk("d1_rise", ri_b, 1);
    step(1);
    chk("d1_rise_drop", ri_b, 0);
    sig_b = 0; step(1);
    chk("d1_stable_lo", st_b, 0); chk("d1_fall", fa_b, 1);
    sig_b = 1; step(1);
    chk("d1_toggle_hi", st_b, 1); chk("d1_toggle_rise", ri_b, 1);
    sig_b = 0; step(1);
    chk("d1_toggle_lo", st_b, 0); chk("d1_toggle_fall", fa_b, 1);
    sig_c = 0; step(4);
    chk("c_stable_lo", st_c, 0); chk("c_fall", fa_c, 1); chk("c_irq", irq_c, 1);
    sig_c = 1; step(2);
    #2 rst_c = 1;
    #1;
    chk("async_stable", st_c, 1); chk("async_rise", ri_c, 0);
    chk("async_fall", fa_c, 0); chk("async_irq", irq_c, 0);
    step(1); rst_c = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("post_rst_rise", ri_c, 0); chk("post_rst_irq", irq_c, 0); chk("post_rst_stable", st_c, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
